// File: rtl/dcache_miss_responder_if.sv
// ============================================================================
// Module : dcache_miss_pkg / dcache_miss_responder_if
// Brief  : Miss-request types and the MSHR / memory / refill handshake bundle
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dcache_miss_pkg;
    localparam int DCACHE_AW = 44;

    typedef enum logic {
        MISS_REFILL = 1'b0,
        MISS_UPDATE = 1'b1
    } miss_cmd_e;

    typedef enum logic [3:0] {
        AMO_NONE = 4'd0,
        AMO_SWAP = 4'd1,
        AMO_ADD  = 4'd2,
        AMO_AND  = 4'd3,
        AMO_OR   = 4'd4,
        AMO_XOR  = 4'd5,
        AMO_MAX  = 4'd6,
        AMO_MAXU = 4'd7,
        AMO_MIN  = 4'd8
    } amo_opcode_e;

    typedef struct packed {
        miss_cmd_e              cmd;
        logic                   cacheable;
        logic                   we;
        logic [7:0]             be;
        logic [63:0]            wdata;
        amo_opcode_e            amo_op;
        logic [DCACHE_AW-1:0]   addr;
        logic [1:0]             update_way;
    } miss_req_bits_t;
endpackage

interface dcache_miss_responder_if;
    import dcache_miss_pkg::*;

    logic                   miss_req_valid;
    logic                   miss_req_ready;
    miss_req_bits_t         miss_req;

    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [DCACHE_AW-1:0]   mem_req_addr;
    logic                   mem_req_we;
    logic [7:0]             mem_req_be;
    logic [63:0]            mem_req_wdata;
    amo_opcode_e            mem_req_amo;

    logic                   mem_rsp_valid;
    logic                   mem_rsp_ready;
    logic [63:0]            mem_rsp_data;

    logic                   refill_valid;
    logic                   refill_ready;
    logic [63:0]            refill_data;
    logic [3:0]             refill_beat;
    logic [1:0]             refill_way;
    logic                   refill_cmd;
    logic                   refill_last;

    // Responder side
    modport slave (
        input  miss_req_valid, miss_req, mem_req_ready,
               mem_rsp_valid, mem_rsp_data, refill_ready,
        output miss_req_ready, mem_req_valid, mem_req_addr, mem_req_we,
               mem_req_be, mem_req_wdata, mem_req_amo, mem_rsp_ready,
               refill_valid, refill_data, refill_beat, refill_way,
               refill_cmd, refill_last
    );

    // MSHR / memory / cache side
    modport master (
        output miss_req_valid, miss_req, mem_req_ready,
               mem_rsp_valid, mem_rsp_data, refill_ready,
        input  miss_req_ready, mem_req_valid, mem_req_addr, mem_req_we,
               mem_req_be, mem_req_wdata, mem_req_amo, mem_rsp_ready,
               refill_valid, refill_data, refill_beat, refill_way,
               refill_cmd, refill_last
    );
endinterface

`default_nettype wire

// File: rtl/dcache_miss_responder.sv
// ============================================================================
// Module : dcache_miss_responder
// Brief  : D-cache miss responder; line refill (16 beats) or single access.
//          Define KIANA_DCACHE_CWF_EN for critical-word-first line order.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_miss_responder
    import dcache_miss_pkg::*;
#(
    parameter int BEATS = 16,
    parameter int AW    = DCACHE_AW
) (
    input  wire logic               clk,
    input  wire logic               rst,
    dcache_miss_responder_if.slave  bus,
    output logic                    busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]     r_state;
    logic [1:0]     w_next;
    miss_req_bits_t r_req;
    logic [3:0]     r_cnt;
    logic           r_refill_valid;
    logic [63:0]    r_refill_data;
    logic [3:0]     r_refill_beat;
    logic           r_refill_last;

    logic           w_line;
    logic [3:0]     w_start;
    logic [3:0]     w_beat;
    logic           w_last;

    assign w_line = (r_req.cmd == MISS_REFILL) && r_req.cacheable;
`ifdef KIANA_DCACHE_CWF_EN
    assign w_start = r_req.addr[6:3];
`else
    assign w_start = 4'd0;
`endif
    // Line beats count from the start index and wrap naturally in 4 bits
    assign w_beat = w_line ? (w_start + r_cnt) : r_req.addr[6:3];
    assign w_last = w_line ? (r_cnt == 4'(BEATS - 1)) : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.miss_req_valid) w_next = S_REQ;
            S_REQ:  if (bus.mem_req_ready)  w_next = S_RSP;
            S_RSP:  if (bus.mem_rsp_valid)  w_next = S_OUT;
            S_OUT:  if (bus.refill_ready)   w_next = w_last ? S_IDLE : S_REQ;
            default:                        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.miss_req_ready = (r_state == S_IDLE);
        bus.mem_req_valid  = (r_state == S_REQ);
        bus.mem_rsp_ready  = (r_state == S_RSP);
        busy               = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req          <= '0;
            r_cnt          <= 4'd0;
            r_refill_valid <= 1'b0;
            r_refill_data  <= 64'd0;
            r_refill_beat  <= 4'd0;
            r_refill_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.miss_req_valid) begin
                    r_req <= bus.miss_req;
                    r_cnt <= 4'd0;
                end
                S_RSP: if (bus.mem_rsp_valid) begin
                    r_refill_valid <= 1'b1;
                    r_refill_data  <= bus.mem_rsp_data;
                    r_refill_beat  <= w_beat;
                    r_refill_last  <= w_last;
                end
                S_OUT: if (bus.refill_ready) begin
                    r_refill_valid <= 1'b0;
                    if (!w_last) r_cnt <= r_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req_addr  = w_line ? {r_req.addr[AW-1:7], w_beat, 3'b000}
                                      : {r_req.addr[AW-1:3], 3'b000};
    assign bus.mem_req_we    = w_line ? 1'b0 : r_req.we;
    assign bus.mem_req_be    = w_line ? 8'hFF : r_req.be;
    assign bus.mem_req_wdata = r_req.wdata;
    assign bus.mem_req_amo   = r_req.amo_op;

    assign bus.refill_valid  = r_refill_valid;
    assign bus.refill_data   = r_refill_data;
    assign bus.refill_beat   = r_refill_beat;
    assign bus.refill_way    = r_req.update_way;
    assign bus.refill_cmd    = r_req.cmd;
    assign bus.refill_last   = r_refill_last;

endmodule

`default_nettype wire

// File: tb/tb_dcache_miss_responder.sv
// ============================================================================
// Module : tb_dcache_miss_responder
// Brief  : Randomized bench for dcache_miss_responder with a line/beat model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache_miss_responder;
    import dcache_miss_pkg::*;

    localparam int AW = DCACHE_AW;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int unsigned salt = 0;
    int   t_acc;

    dcache_miss_responder_if bus_if();

    dcache_miss_responder dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
        return {a[31:0] ^ 32'h5A5A_0000 ^ salt, ~a[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input miss_req_bits_t r);
        int k = 0;
        bus_if.miss_req       = r;
        bus_if.miss_req_valid = 1'b1;
        while (!bus_if.miss_req_ready && k < 20) begin
            step();
            k++;
        end
        check("miss_req_ready", bus_if.miss_req_ready, 1);
        step();
        t_acc = cyc;
        bus_if.miss_req_valid = 1'b0;
    endtask

    // One beat: memory request, memory response, refill to cache
    task automatic do_beat(input miss_req_bits_t r, input logic [AW-1:0] ea, input logic ewe,
                           input logic [7:0] ebe, input logic [3:0] ebeat, input logic elast,
                           input int dreq, input int drsp, input int dref);
        int k = 0;
        while (!bus_if.mem_req_valid && k < 50) begin
            step();
            k++;
        end
        check("mem_req_valid", bus_if.mem_req_valid, 1);
        for (int d = 0; d <= dreq; d++) begin
            check("mem_req_addr", bus_if.mem_req_addr, ea);
            check("mem_req_we", bus_if.mem_req_we, ewe);
            check("mem_req_be", bus_if.mem_req_be, ebe);
            check("mem_req_amo", bus_if.mem_req_amo, r.amo_op);
            if (ewe) check("mem_req_wdata", bus_if.mem_req_wdata, r.wdata);
            check("busy_miss_ready", bus_if.miss_req_ready, 0);
            check("rsp_ready_in_req", bus_if.mem_rsp_ready, 0);
            if (d < dreq) begin
                // Junk response offered early must be ignored
                bus_if.mem_rsp_valid = 1'b1;
                bus_if.mem_rsp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
                step();
                bus_if.mem_rsp_valid = 1'b0;
            end
        end
        bus_if.mem_req_ready = 1'b1;
        step();
        bus_if.mem_req_ready = 1'b0;
        for (int d = 0; d <= drsp; d++) begin
            check("mem_rsp_ready", bus_if.mem_rsp_ready, 1);
            check("req_valid_in_rsp", bus_if.mem_req_valid, 0);
            if (d < drsp) step();
        end
        bus_if.mem_rsp_valid = 1'b1;
        bus_if.mem_rsp_data  = mem_word(ea);
        step();
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.mem_rsp_data  = {$urandom, $urandom};
        for (int d = 0; d <= dref; d++) begin
            check("refill_valid", bus_if.refill_valid, 1);
            check("refill_data", bus_if.refill_data, mem_word(ea));
            check("refill_beat", bus_if.refill_beat, ebeat);
            check("refill_way", bus_if.refill_way, r.update_way);
            check("refill_cmd", bus_if.refill_cmd, r.cmd);
            check("refill_last", bus_if.refill_last, elast);
            check("busy_miss_ready", bus_if.miss_req_ready, 0);
            if (d < dref) step();
        end
        bus_if.refill_ready = 1'b1;
        step();
        bus_if.refill_ready = 1'b0;
    endtask

    // Reference: line mode walks 16 beats from the start index modulo 16
    task automatic run_txn(input miss_req_bits_t r, input int maxd, input int stall_beat,
                           input int abort_beat);
        bit           line;
        int           n;
        int           start;
        int           beat;
        logic [AW-1:0] ea;
        logic [AW-1:0] base;
        salt  = $urandom;
        line  = (r.cmd == MISS_REFILL) && r.cacheable;
        n     = line ? 16 : 1;
`ifdef KIANA_DCACHE_CWF_EN
        start = line ? int'(r.addr[6:3]) : 0;
`else
        start = 0;
`endif
        base  = (r.addr >> 7) << 7;
        send(r);
        for (int i = 0; i < n; i++) begin
            if (i == abort_beat) begin
                int k = 0;
                while (!bus_if.mem_req_valid && k < 50) begin
                    step();
                    k++;
                end
                return;
            end
            beat = line ? (start + i) % 16 : int'(r.addr[6:3]);
            ea   = line ? base + AW'(beat * 8) : (r.addr >> 3) << 3;
            do_beat(r, ea, line ? 1'b0 : r.we, line ? 8'hFF : r.be, 4'(beat), i == n - 1,
                    (i == stall_beat) ? 5 : int'($urandom_range(0, maxd)),
                    (maxd == 0) ? 0 : int'($urandom_range(0, maxd)),
                    (i == stall_beat) ? 5 : int'($urandom_range(0, maxd)));
        end
        check("idle_after_txn", {busy, bus_if.miss_req_ready}, 2'b01);
    endtask

    function automatic miss_req_bits_t mk(input miss_cmd_e cmd, input logic cach, input logic we,
                                           input logic [7:0] be, input logic [63:0] wd,
                                           input logic [AW-1:0] a, input logic [1:0] way);
        miss_req_bits_t r;
        r.cmd = cmd;  r.cacheable = cach;  r.we = we;  r.be = be;  r.wdata = wd;
        r.amo_op = AMO_NONE;  r.addr = a;  r.update_way = way;
        return r;
    endfunction

    initial begin
        miss_req_bits_t r;
        logic [63:0]    rnd;
        rst                   = 1'b1;
        bus_if.miss_req_valid = 1'b0;
        bus_if.miss_req       = '0;
        bus_if.mem_req_ready  = 1'b0;
        bus_if.mem_rsp_valid  = 1'b0;
        bus_if.mem_rsp_data   = 64'd0;
        bus_if.refill_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_miss_ready", bus_if.miss_req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_mem_req", {bus_if.mem_req_valid, bus_if.mem_rsp_ready, bus_if.mem_req_we,
                              bus_if.mem_req_be}, 0);
        check("rst_mem_addr", bus_if.mem_req_addr, 0);
        check("rst_refill", {bus_if.refill_valid, bus_if.refill_last, bus_if.refill_beat,
                             bus_if.refill_way, bus_if.refill_cmd}, 0);
        check("rst_refill_data", bus_if.refill_data, 0);
        rst = 1'b0;
        step();

        // Zero-wait line refill: 16 beats x 3 cycles
        run_txn(mk(MISS_REFILL, 1, 0, 8'h00, 64'd0, 44'h0_1234_5678, 2'd2), 0, -1, -1);
        check("line_latency", 64'(cyc - t_acc), 64'd48);

        run_txn(mk(MISS_UPDATE, 1, 1, 8'h0F, 64'hDEAD_BEEF, 44'h1004, 2'd1), 0, -1, -1);
        check("single_latency", 64'(cyc - t_acc), 64'd3);
        run_txn(mk(MISS_REFILL, 0, 0, 8'hFF, 64'd0, 44'h2088, 2'd3), 2, -1, -1);
        run_txn(mk(MISS_REFILL, 1, 0, 8'h00, 64'd0, 44'h3068, 2'd0), 1, -1, -1);
        run_txn(mk(MISS_REFILL, 1, 0, 8'h00, 64'd0, 44'h4000, 2'd1), 0, 7, -1);

        // Reset in the middle of a refill, then a clean refill
        run_txn(mk(MISS_REFILL, 1, 0, 8'h00, 64'd0, 44'h5000, 2'd2), 1, -1, 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_refill_valid", bus_if.refill_valid, 0);
        check("midrst_mem_req_valid", bus_if.mem_req_valid, 0);
        check("midrst_miss_ready", bus_if.miss_req_ready, 1);
        run_txn(mk(MISS_REFILL, 1, 0, 8'h00, 64'd0, 44'h6040, 2'd3), 0, -1, -1);

        for (int t = 0; t < 30; t++) begin
            rnd          = {$urandom, $urandom};
            r.cmd        = miss_cmd_e'($urandom_range(0, 1));
            r.cacheable  = 1'($urandom_range(0, 1));
            r.we         = 1'($urandom_range(0, 1));
            r.be         = 8'($urandom);
            r.wdata      = {$urandom, $urandom};
            r.amo_op     = amo_opcode_e'(4'($urandom_range(0, 8)));
            r.addr       = rnd[AW-1:0];
            r.update_way = 2'($urandom);
            run_txn(r, 3, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
